// File: rtl/layer1_fmap_buffer_if.sv
// ---------------------------------------------------------------------------
// layer1_fmap_buffer_if
// Bundles the signals between layer1 (producer), the layer-1 feature-map
// buffer and the layer-2 reader.
//   master : drives the capture inputs (din, din_valid, layer_finish, clr)
//            and the read request (rd_en, rd_ch, rd_addr); observes the read
//            result and the status flags.
//   slave  : the feature-map buffer itself.
// din packs channel 0 in the MSBs; din_valid bit CHANNELS-1 belongs to
// channel 0, so both vectors share the same concatenation order.
// ---------------------------------------------------------------------------
interface layer1_fmap_buffer_if #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 6,
    parameter int ADDR_W   = 8
);
    localparam int CH_W = $clog2(CHANNELS);

    logic [CHANNELS*DATA_W-1:0] din;
    logic [CHANNELS-1:0]        din_valid;
    logic                       layer_finish;
    logic                       clr;
    logic                       rd_en;
    logic [CH_W-1:0]            rd_ch;
    logic [ADDR_W-1:0]          rd_addr;
    logic signed [DATA_W-1:0]   rd_data;
    logic                       rd_valid;
    logic                       done;
    logic                       overflow;
    logic                       underrun;

    modport master (
        output din, din_valid, layer_finish, clr, rd_en, rd_ch, rd_addr,
        input  rd_data, rd_valid, done, overflow, underrun
    );

    modport slave (
        input  din, din_valid, layer_finish, clr, rd_en, rd_ch, rd_addr,
        output rd_data, rd_valid, done, overflow, underrun
    );
endinterface

// File: rtl/layer1_fmap_buffer.sv
// ---------------------------------------------------------------------------
// layer1_fmap_buffer
// Captures the pooled output streams of layer1 into per-channel 14x14 maps
// and serves them to layer 2 through a registered read port (1-cycle
// latency, one word per cycle).
// Ports:
//   clk    : single rising-edge clock
//   reset  : synchronous, active-high; clears state, pointers and flags
//            (memory contents are kept)
//   bus    : layer1_fmap_buffer_if.slave
//            din/din_valid    per-channel sample and write strobe
//            layer_finish     producer done (may end capture early)
//            clr              restart capture, honoured only in DONE
//            rd_en/rd_ch/rd_addr -> rd_data/rd_valid one cycle later
//            done, overflow (sticky), underrun (sticky)
// ---------------------------------------------------------------------------
module layer1_fmap_buffer #(
    parameter int DATA_W    = 16,
    parameter int CHANNELS  = 6,
    parameter int MAP_WORDS = 196,
    parameter int ADDR_W    = 8
) (
    input logic                 clk,
    input logic                 reset,
    layer1_fmap_buffer_if.slave bus
);
    localparam int MEM_AW = $clog2(MAP_WORDS);
    localparam int WP_W   = $clog2(MAP_WORDS + 1);
    localparam int CH_W   = $clog2(CHANNELS);

    localparam logic [WP_W-1:0]   WP_FULL  = WP_W'(MAP_WORDS);
    localparam logic [CH_W:0]     CH_LIM   = (CH_W + 1)'(CHANNELS);
    localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(MAP_WORDS);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] mem [CHANNELS][MAP_WORDS];

    logic [WP_W-1:0]     wp     [CHANNELS];
    logic [WP_W-1:0]     wp_nxt [CHANNELS];
    logic [CHANNELS-1:0] wr_en;
    logic                ovf_hit;
    logic                all_full;
    logic                underrun_set;
    logic                clr_ptr;
    logic                overflow_q;
    logic                underrun_q;
    logic                rd_in_range;

    logic signed [DATA_W-1:0] rd_data_p1;
    logic                     vld_p1;

    // Channel c lives in the c-th slice counted from the MSB end.
    function automatic logic signed [DATA_W-1:0] ch_sample(
        input logic [CHANNELS*DATA_W-1:0] packed_din,
        input int                         c
    );
        return packed_din[(CHANNELS-1-c)*DATA_W +: DATA_W];
    endfunction

    // Next-state, write enables and post-update pointers. The completion
    // test looks at the pointers after this cycle's writes so the last
    // accepted sample moves the FSM to DONE on the same edge.
    always_comb begin
        state_nxt    = state;
        ovf_hit      = 1'b0;
        all_full     = 1'b1;
        underrun_set = 1'b0;
        clr_ptr      = 1'b0;
        wr_en        = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wp_nxt[c] = wp[c];
            if (state == FILL && bus.din_valid[CHANNELS-1-c]) begin
                if (wp[c] < WP_FULL) begin
                    wr_en[c]  = 1'b1;
                    wp_nxt[c] = wp[c] + 1'b1;
                end else begin
                    ovf_hit = 1'b1;
                end
            end
            if (wp_nxt[c] != WP_FULL) begin
                all_full = 1'b0;
            end
        end

        case (state)
            IDLE: state_nxt = FILL;
            FILL: begin
                if (all_full) begin
                    state_nxt = DONE;
                end else if (bus.layer_finish) begin
                    state_nxt    = DONE;
                    underrun_set = 1'b1;
                end
            end
            DONE: begin
                if (bus.clr) begin
                    state_nxt = FILL;
                    clr_ptr   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pointers and sticky flags; clr leaves the flags untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wp[c] <= '0;
            end
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                wp[c] <= clr_ptr ? '0 : wp_nxt[c];
            end
            if (ovf_hit) begin
                overflow_q <= 1'b1;
            end
            if (underrun_set) begin
                underrun_q <= 1'b1;
            end
        end
    end

    // Capture stage: storage has no reset so stale words survive a restart.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_en[c]) begin
                mem[c][wp[c][MEM_AW-1:0]] <= ch_sample(bus.din, c);
            end
        end
    end

    assign rd_in_range = ({1'b0, bus.rd_ch} < CH_LIM) && (bus.rd_addr < ADDR_LIM);

    // Read stage p1: the memory read sees pre-write contents on a same-word
    // collision; out-of-range requests still return a valid zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            vld_p1 <= bus.rd_en;
            if (bus.rd_en) begin
                if (rd_in_range) begin
                    rd_data_p1 <= mem[bus.rd_ch][bus.rd_addr[MEM_AW-1:0]];
                end else begin
                    rd_data_p1 <= '0;
                end
            end
        end
    end

    assign bus.rd_data  = rd_data_p1;
    assign bus.rd_valid = vld_p1;
    assign bus.done     = (state == DONE);
    assign bus.overflow = overflow_q;
    assign bus.underrun = underrun_q;
endmodule

// File: tb/tb_layer1_fmap_buffer.sv
// ---------------------------------------------------------------------------
// tb_layer1_fmap_buffer
// Directed bench for layer1_fmap_buffer. Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point, so each step() shows
// the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_layer1_fmap_buffer;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    layer1_fmap_buffer_if #(.DATA_W(16), .CHANNELS(6), .ADDR_W(8)) bus();

    layer1_fmap_buffer #(
        .DATA_W(16), .CHANNELS(6), .MAP_WORDS(196), .ADDR_W(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wr();
        bus.din_valid    = '0;
        bus.layer_finish = 1'b0;
        bus.clr          = 1'b0;
    endtask

    task automatic put(input int c, input int v);
        bus.din[(5-c)*16 +: 16] = 16'(v);
        bus.din_valid[5-c]      = 1'b1;
    endtask

    task automatic rd_req(input int ch, input int addr);
        bus.rd_en   = 1'b1;
        bus.rd_ch   = 3'(ch);
        bus.rd_addr = 8'(addr);
        step();
    endtask

    task automatic do_clr();
        clear_wr();
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_wr();
        bus.rd_en = 1'b0;
        step();
        step();
        tests++; if (bus.rd_data !== 16'sd0) begin fails++; $display("FAIL reset_rd_data: got %0d want 0", bus.rd_data); end
        tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.done); end
        tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        tests++; if (bus.underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b want 0", bus.underrun); end
        reset = 1'b0;
        step();   // IDLE -> FILL
    endtask

    task automatic test_full_capture();
        for (int i = 0; i < 196; i++) begin
            clear_wr();
            for (int c = 0; c < 6; c++) put(c, c*1000 + i);
            step();
            if (i == 194) begin
                tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL full_done_early: got %b want 0", bus.done); end
            end
            if (i == 195) begin
                tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL full_done_at_195: got %b want 1", bus.done); end
            end
        end
        clear_wr();
        // Back-to-back read of every word with rd_en held high.
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < 196; i++) begin
                rd_req(c, i);
                tests++;
                if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'(c*1000 + i)) begin
                    fails++;
                    $display("FAIL full_read c=%0d i=%0d: got %0d vld=%b want %0d vld=1", c, i, bus.rd_data, bus.rd_valid, c*1000 + i);
                end
            end
        end
        bus.rd_en = 1'b0;
        step();
        tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL rd_valid_drop: got %b want 0", bus.rd_valid); end
        tests++; if (bus.rd_data !== 16'sd5195) begin fails++; $display("FAIL rd_data_hold: got %0d want 5195", bus.rd_data); end
    endtask

    task automatic test_read_edges();
        rd_req(6, 0);
        tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'sd0) begin fails++; $display("FAIL rd_ch6: got %0d vld=%b want 0 vld=1", bus.rd_data, bus.rd_valid); end
        rd_req(0, 200);
        tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'sd0) begin fails++; $display("FAIL rd_addr200: got %0d vld=%b want 0 vld=1", bus.rd_data, bus.rd_valid); end
        rd_req(1, 10);
        tests++; if (bus.rd_data !== 16'sd1010) begin fails++; $display("FAIL rd_after_oob: got %0d want 1010", bus.rd_data); end
        rd_req(7, 3);
        tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'sd0) begin fails++; $display("FAIL rd_ch7: got %0d vld=%b want 0 vld=1", bus.rd_data, bus.rd_valid); end
        bus.rd_en = 1'b0;
        step();
    endtask

    task automatic test_staggered();
        do_clr();
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL clr_done_fall: got %b want 0", bus.done); end
        for (int k = 0; k < 206; k++) begin
            clear_wr();
            if (k < 196) for (int c = 0; c < 5; c++) put(c, 30000 - c*1000 - k);
            if (k >= 10) put(5, 25000 - (k - 10));
            step();
            if (k == 195 || k == 204) begin
                tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL stag_done_early k=%0d: got %b want 0", k, bus.done); end
            end
            if (k == 205) begin
                tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL stag_done: got %b want 1", bus.done); end
                tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL stag_overflow: got %b want 0", bus.overflow); end
            end
        end
        clear_wr();
        rd_req(0, 195);
        tests++; if (bus.rd_data !== 16'sd29805) begin fails++; $display("FAIL stag_c0_w195: got %0d want 29805", bus.rd_data); end
        rd_req(5, 0);
        tests++; if (bus.rd_data !== 16'sd25000) begin fails++; $display("FAIL stag_c5_w0: got %0d want 25000", bus.rd_data); end
        rd_req(5, 195);
        tests++; if (bus.rd_data !== 16'sd24805) begin fails++; $display("FAIL stag_c5_w195: got %0d want 24805", bus.rd_data); end
        rd_req(4, 100);
        tests++; if (bus.rd_data !== 16'sd25900) begin fails++; $display("FAIL stag_c4_w100: got %0d want 25900", bus.rd_data); end
        bus.rd_en = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        do_clr();
        for (int k = 0; k < 197; k++) begin
            clear_wr();
            put(0, 20000 + k);
            if (k >= 1) for (int c = 1; c < 6; c++) put(c, c*1000 + 500 + (k - 1));
            step();
            if (k == 195) begin
                tests++; if (bus.overflow !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL ovf_early: got ovf=%b done=%b want 0 0", bus.overflow, bus.done); end
            end
            if (k == 196) begin
                tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
                tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL ovf_done: got %b want 1", bus.done); end
            end
        end
        clear_wr();
        rd_req(0, 195);
        tests++; if (bus.rd_data !== 16'sd20195) begin fails++; $display("FAIL ovf_c0_w195: got %0d want 20195", bus.rd_data); end
        rd_req(0, 0);
        tests++; if (bus.rd_data !== 16'sd20000) begin fails++; $display("FAIL ovf_c0_w0: got %0d want 20000", bus.rd_data); end
        rd_req(5, 195);
        tests++; if (bus.rd_data !== 16'sd5695) begin fails++; $display("FAIL ovf_c5_w195: got %0d want 5695", bus.rd_data); end
        bus.rd_en = 1'b0;
        step();
    endtask

    task automatic test_early_finish();
        do_clr();
        for (int i = 0; i < 100; i++) begin
            clear_wr();
            for (int c = 0; c < 6; c++) put(c, -1 - c*1000 - i);
            step();
        end
        clear_wr();
        tests++; if (bus.done !== 1'b0 || bus.underrun !== 1'b0) begin fails++; $display("FAIL early_pre: got done=%b und=%b want 0 0", bus.done, bus.underrun); end
        bus.layer_finish = 1'b1;
        step();
        bus.layer_finish = 1'b0;
        tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL early_done: got %b want 1", bus.done); end
        tests++; if (bus.underrun !== 1'b1) begin fails++; $display("FAIL early_underrun: got %b want 1", bus.underrun); end
        tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky_clr: got %b want 1", bus.overflow); end
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < 100; i++) begin
                rd_req(c, i);
                tests++;
                if (bus.rd_data !== 16'(-1 - c*1000 - i)) begin
                    fails++;
                    $display("FAIL early_read c=%0d i=%0d: got %0d want %0d", c, i, bus.rd_data, -1 - c*1000 - i);
                end
            end
        end
        bus.rd_en = 1'b0;
        step();
    endtask

    task automatic test_read_during_write();
        do_clr();
        for (int i = 0; i < 6; i++) begin
            clear_wr();
            put(0, 7000 + i);
            if (i == 5) begin
                bus.rd_en   = 1'b1;
                bus.rd_ch   = 3'd0;
                bus.rd_addr = 8'd5;
            end
            step();
        end
        clear_wr();
        tests++; if (bus.rd_data !== -16'sd6) begin fails++; $display("FAIL rdw_old: got %0d want -6", bus.rd_data); end
        rd_req(0, 5);
        tests++; if (bus.rd_data !== 16'sd7005) begin fails++; $display("FAIL rdw_new: got %0d want 7005", bus.rd_data); end
        bus.rd_en = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_fill();
        for (int i = 0; i < 50; i++) begin
            clear_wr();
            for (int c = 0; c < 6; c++) put(c, 100 + i);
            step();
        end
        clear_wr();
        rd_req(0, 0);
        bus.rd_en = 1'b0;
        tests++; if (bus.rd_data !== 16'sd7000) begin fails++; $display("FAIL mid_pre_read: got %0d want 7000", bus.rd_data); end
        reset = 1'b1;
        step();
        tests++; if (bus.rd_data !== 16'sd0 || bus.rd_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_rd: got %0d vld=%b want 0 vld=0", bus.rd_data, bus.rd_valid); end
        tests++; if (bus.done !== 1'b0 || bus.overflow !== 1'b0 || bus.underrun !== 1'b0) begin fails++; $display("FAIL mid_reset_flags: got done=%b ovf=%b und=%b want 0 0 0", bus.done, bus.overflow, bus.underrun); end
        reset = 1'b0;
        step();
        for (int i = 0; i < 196; i++) begin
            clear_wr();
            for (int c = 0; c < 6; c++) put(c, 12000 + c*300 + i);
            step();
            if (i == 194) begin
                tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL mid_refill_early: got %b want 0", bus.done); end
            end
            if (i == 195) begin
                tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL mid_refill_done: got %b want 1", bus.done); end
                tests++; if (bus.overflow !== 1'b0 || bus.underrun !== 1'b0) begin fails++; $display("FAIL mid_refill_flags: got ovf=%b und=%b want 0 0", bus.overflow, bus.underrun); end
            end
        end
        clear_wr();
        rd_req(0, 0);
        tests++; if (bus.rd_data !== 16'sd12000) begin fails++; $display("FAIL mid_c0_w0: got %0d want 12000", bus.rd_data); end
        rd_req(5, 195);
        tests++; if (bus.rd_data !== 16'sd13695) begin fails++; $display("FAIL mid_c5_w195: got %0d want 13695", bus.rd_data); end
        rd_req(3, 50);
        tests++; if (bus.rd_data !== 16'sd12950) begin fails++; $display("FAIL mid_c3_w50: got %0d want 12950", bus.rd_data); end
        bus.rd_en = 1'b0;
        step();
    endtask

    initial begin
        reset            = 1'b1;
        bus.din          = '0;
        bus.din_valid    = '0;
        bus.layer_finish = 1'b0;
        bus.clr          = 1'b0;
        bus.rd_en        = 1'b0;
        bus.rd_ch        = '0;
        bus.rd_addr      = '0;
        test_reset();
        test_full_capture();
        test_read_edges();
        test_staggered();
        test_overflow();
        test_early_finish();
        test_read_during_write();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/layer1_fmap_buffer.md
# layer1_fmap_buffer

Receive-side counterpart to the layer-1 input feed. It captures the six pooled 16-bit output streams of `layer1` into per-channel feature-map storage of 14×14 words each. It then serves the stored maps to the next layer through a registered, address-driven read port with 1-cycle latency. It sits between `layer1` and layer 2 and replaces the ad-hoc probing of `dout` and `layer1_out` used during bring-up.

## Interface
Parameters:
- `DATA_W`, 16: sample width, signed two's complement.
- `CHANNELS`, 6: number of layer-1 output channels.
- `MAP_WORDS`, 196: words per channel (14×14 pooled map).
- `ADDR_W`, 8: read/write address width; requires 2^ADDR_W ≥ MAP_WORDS.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `din`, in, CHANNELS*DATA_W: concatenated samples; channel 0 occupies the MSBs `[95:80]`, channel 5 the LSBs `[15:0]`.
- `din_valid`, in, CHANNELS: per-channel write strobe; bit 5 = channel 0 (same concatenation order as `din`).
- `layer_finish`, in, 1: level or pulse from `layer1` meaning the producer is done.
- `clr`, in, 1: restart capture; has effect only in DONE.
- `rd_en`, in, 1: read request.
- `rd_ch`, in, 3: channel to read.
- `rd_addr`, in, ADDR_W: word index, raster order (row*14+col).
- `rd_data`, out, DATA_W: read result.
- `rd_valid`, out, 1: `rd_data` is valid this cycle.
- `done`, out, 1: high while in DONE.
- `overflow`, out, 1: sticky; a write arrived on a channel that was already full.
- `underrun`, out, 1: sticky; `layer_finish` arrived before all channels were full.

## Operation
- Storage: CHANNELS × MAP_WORDS words, held either as one RAM per channel or as a flat RAM addressed by ch*MAP_WORDS+addr.
- Each channel has its own write pointer `wp[c]`, range 0..MAP_WORDS.
- States:
  - IDLE: entered on reset. Moves to FILL on the next cycle unconditionally.
  - FILL: for each c, if the `din_valid` bit for c is set and wp[c] < MAP_WORDS, write the channel-c slice of `din` to mem[c][wp[c]] and set wp[c]++.
    - If the bit is set and wp[c] == MAP_WORDS, drop the sample and set `overflow`.
    - Channels are written independently, and simultaneous writes to all six channels are legal.
  - FILL → DONE when every wp[c] == MAP_WORDS. The comparison uses the post-update pointers, so the cycle that completes the last channel causes the transition on that same edge.
  - FILL → DONE when `layer_finish` = 1 while not all channels are full. In this case also set `underrun`. Writes presented in that same cycle are still accepted.
  - DONE: `din_valid` is ignored and no overflow is flagged. `clr` = 1 zeroes all wp[c] and moves to FILL next cycle; `overflow` and `underrun` are kept.
- Reads are accepted in every state.
  - If rd_ch ≥ CHANNELS or rd_addr ≥ MAP_WORDS, `rd_data` = 0 with `rd_valid` still asserted.
  - Read-during-write to the same word returns the old content.
- Reset clears the state, all pointers, and all flags. It does not clear memory contents.
- Reset mid-FILL discards partial capture. Subsequent reads of unwritten words return stale data, and this is legal.

## Timing
- Reset values: `rd_data` = 0, `rd_valid` = 0, `done` = 0, `overflow` = 0, `underrun` = 0.
- Write latency: a sample presented at edge N is readable by a `rd_en` sampled at edge N+1.
- Read latency is exactly 1 cycle: `rd_en` at edge N gives `rd_valid` = 1 and `rd_data` at edge N+1. `rd_valid` drops the cycle after `rd_en` falls.
- Back-to-back reads are supported at one word per cycle with no bubbles.
- `rd_data` holds its last value while `rd_valid` = 0.
- `done` rises at the edge where the state becomes DONE, and falls the edge after `clr` is sampled.
- `overflow` and `underrun` set on the edge of the offending event. Only `reset` clears them.

## Test plan
- **Full capture:** drive 196 cycles with all six `din_valid` bits high and channel c sample = c*1000+i. Then read every (c,i). Required: each read returns c*1000+i, and `done` is first seen high at the edge that accepts sample 195.
- **Staggered channels:** channel 5 starts 10 cycles late. Required: `done` stays low until channel 5's 196th write; channels 0–4 see no overflow while idle and full.
- **Overflow:** after DONE, issue `clr`, refill channel 0 with 197 samples and the other channels with 196. Required: `overflow` = 1 and word 195 of channel 0 holds the 196th sample, not the 197th.
- **Early finish:** pulse `layer_finish` after 100 writes per channel. Required: DONE next edge, `underrun` = 1, and reads of words 0..99 return correct data.
- **Read edge cases:** `rd_ch` = 6 or `rd_addr` = 200 returns 0 with `rd_valid` = 1. A read of word 5 in the same cycle it is written returns the pre-write value.
- **Reset mid-fill:** assert `reset` after 50 writes. Required: all outputs return to reset values, the pointers restart, and a new fill of 196 words reaches DONE normally.
